// File: rtl/rapcla_pkg.sv
// rtl/rapcla_pkg.sv - shared types, mode encodings and approximate-carry helper
package rapcla_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CORRECT = 1'b1
  } state_t;

  localparam logic MODE_APPROX = 1'b0;
  localparam logic MODE_EXACT  = 1'b1;

  localparam int MAX_W = 64;

  // Carry i is the carry-out of bits max(0,i-window)..i with carry-in 0.
  function automatic logic [MAX_W-1:0] appc_vec(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input int               width,
    input int               window
  );
    logic [MAX_W-1:0] res;
    logic             c;
    res = '0;
    for (int i = 0; i < MAX_W; i++) begin
      c = 1'b0;
      for (int j = 0; j <= i; j++) begin
        if (i < width && j >= i - window) begin
          c = (a[j] & b[j]) | ((a[j] ^ b[j]) & c);
        end
      end
      res[i] = c;
    end
    return res;
  endfunction

endpackage

// File: rtl/rapcla_spec.sv
// rtl/rapcla_spec.sv - combinational windowed-carry sum and exact error detect
module rapcla_spec
  import rapcla_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH:0]   o_sum,
  output logic             o_err
);

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_appc;
  logic [WIDTH:0]   w_sum;
  logic             w_err;

  assign w_p    = i_a ^ i_b;
  assign w_appc = WIDTH'(appc_vec(MAX_W'(i_a), MAX_W'(i_b), WIDTH, WINDOW));

  always_comb begin
    w_sum        = '0;
    w_sum[0]     = w_p[0];
    for (int i = 1; i < WIDTH; i++) begin
      w_sum[i] = w_p[i] ^ w_appc[i-1];
    end
    w_sum[WIDTH] = w_appc[WIDTH-1];
  end

  // A full-window propagate run fed by a carry the window cannot see; i==WINDOW has no such carry.
  always_comb begin
    w_err = 1'b0;
    for (int i = WINDOW + 1; i < WIDTH; i++) begin
      w_err = w_err | ((&w_p[i-WINDOW +: WINDOW+1]) & w_appc[i-WINDOW-1]);
    end
  end

  assign o_sum = w_sum;
  assign o_err = w_err;

endmodule

// File: rtl/rapcla_vl.sv
// rtl/rapcla_vl.sv - variable-latency speculative adder with one-cycle correction
module rapcla_vl
  import rapcla_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  state_t           r_state;
  state_t           w_next_state;
  logic             w_ready;
  logic             w_accept;
  logic             w_to_correct;
  logic             w_load_app;
  logic             w_load_exact;
  logic [WIDTH:0]   w_app_sum;
  logic             w_app_err;
  logic [WIDTH:0]   w_exact_sum;
  logic [WIDTH-1:0] r_cap_a;
  logic [WIDTH-1:0] r_cap_b;
  logic             r_out_valid;
  logic [WIDTH:0]   r_sum;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;

  rapcla_spec #(
    .WIDTH (WIDTH),
    .WINDOW(WINDOW)
  ) u_spec (
    .i_a  (a),
    .i_b  (b),
    .o_sum(w_app_sum),
    .o_err(w_app_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_to_correct) w_next_state = CORRECT;
      CORRECT: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_ready      = (r_state == IDLE) & (~r_out_valid | out_ready);
    w_accept     = in_valid & w_ready;
    w_to_correct = w_accept & (mode == MODE_EXACT) & w_app_err;
    w_load_app   = w_accept & ~w_to_correct;
    w_load_exact = (r_state == CORRECT);
  end

  // The only full adder; it sees captured operands, never the live inputs.
  assign w_exact_sum = {1'b0, r_cap_a} + {1'b0, r_cap_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_a <= '0;
      r_cap_b <= '0;
    end else if (w_to_correct) begin
      r_cap_a <= a;
      r_cap_b <= b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_err       <= 1'b0;
    end else if (w_load_exact) begin
      r_out_valid <= 1'b1;
      r_sum       <= w_exact_sum;
      r_err       <= 1'b1;
    end else if (w_load_app) begin
      r_out_valid <= 1'b1;
      r_sum       <= w_app_sum;
      r_err       <= w_app_err;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_accept && w_app_err && (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_rapcla_vl.sv
// tb/tb_rapcla_vl.sv - randomized and directed self-checking bench for rapcla_vl
module tb_rapcla_vl;

  localparam int NCFG = 10;
  localparam int CW   [NCFG] = '{8, 8, 4, 4, 8, 8, 8, 16, 16, 16};
  localparam int CWIN [NCFG] = '{4, 4, 1, 3, 1, 3, 7, 1,  3,  15};
  localparam int CCNT [NCFG] = '{16, 4, 16, 16, 16, 16, 16, 16, 16, 16};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid  [NCFG];
  logic        mode      [NCFG];
  logic        out_ready [NCFG];
  logic [15:0] a         [NCFG];
  logic [15:0] b         [NCFG];
  wire         in_ready_w  [NCFG];
  wire         out_valid_w [NCFG];
  wire         err_w       [NCFG];
  wire  [16:0] sum_w       [NCFG];
  wire  [15:0] cnt_w       [NCFG];

  for (genvar gk = 0; gk < NCFG; gk++) begin : g_dut
    localparam int W = CW[gk];
    wire [W:0]          s;
    wire [CCNT[gk]-1:0] c;
    assign sum_w[gk] = 17'(s);
    assign cnt_w[gk] = 16'(c);
    rapcla_vl #(
      .WIDTH (W),
      .WINDOW(CWIN[gk]),
      .CNT_W (CCNT[gk])
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[gk]),
      .in_ready (in_ready_w[gk]),
      .a        (a[gk][W-1:0]),
      .b        (b[gk][W-1:0]),
      .mode     (mode[gk]),
      .out_valid(out_valid_w[gk]),
      .out_ready(out_ready[gk]),
      .sum      (s),
      .err      (err_w[gk]),
      .err_cnt  (c)
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  // Expected state of each instance's output slot, pending correction and counter.
  bit mov  [NCFG];
  bit merr [NCFG];
  bit pend [NCFG];
  int msum [NCFG];
  int psum [NCFG];
  int mcnt [NCFG];

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h", nm, k, act, exp);
    end
  endtask

  // Each windowed carry is the carry-out of a plain addition of the window's bit slices.
  function automatic int approx_sum(input int x, input int y, input int w, input int win);
    int carry [16];
    int lo, n, m, seg, r;
    for (int i = 0; i < w; i++) begin
      lo = (i > win) ? i - win : 0;
      n = i - lo + 1;
      m = (1 << n) - 1;
      seg = ((x >> lo) & m) + ((y >> lo) & m);
      carry[i] = (seg >> n) & 1;
    end
    r = (x ^ y) & 1;
    for (int i = 1; i < w; i++) begin
      r = r | ((((x >> i) ^ (y >> i) ^ carry[i-1]) & 1) << i);
    end
    r = r | (carry[w-1] << w);
    return r;
  endfunction

  task automatic mreset();
    for (int k = 0; k < NCFG; k++) begin
      mov[k] = 0; merr[k] = 0; pend[k] = 0; msum[k] = 0; psum[k] = 0; mcnt[k] = 0;
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < NCFG; k++) begin
      in_valid[k] = 1'b0; mode[k] = 1'b0; out_ready[k] = 1'b1; a[k] = '0; b[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    bit rdy, acc, e;
    int ap, ex;
    rdy = !pend[k] && (!mov[k] || out_ready[k]);
    acc = in_valid[k] && rdy;
    ex  = int'(a[k]) + int'(b[k]);
    ap  = approx_sum(int'(a[k]), int'(b[k]), CW[k], CWIN[k]);
    e   = (ap != ex);
    if (pend[k]) begin
      mov[k] = 1; msum[k] = psum[k]; merr[k] = 1; pend[k] = 0;
    end else if (acc && mode[k] && e) begin
      pend[k] = 1; psum[k] = ex;
      if (out_ready[k]) mov[k] = 0;
    end else if (acc) begin
      mov[k] = 1; msum[k] = ap; merr[k] = e;
    end else if (out_ready[k]) begin
      mov[k] = 0;
    end
    if (acc && e && mcnt[k] < (1 << CCNT[k]) - 1) mcnt[k]++;
  endtask

  // Inputs are driven just after a negedge; this checks readiness, advances one edge, then checks outputs.
  task automatic cycle();
    #1;
    for (int k = 0; k < NCFG; k++) begin
      chk("in_ready", k, int'(in_ready_w[k]), int'(!pend[k] && (!mov[k] || out_ready[k])));
    end
    @(posedge clk);
    if (!rst_n) mreset();
    else for (int k = 0; k < NCFG; k++) model_step(k);
    @(negedge clk);
    for (int k = 0; k < NCFG; k++) begin
      chk("out_valid", k, int'(out_valid_w[k]), int'(mov[k]));
      if (mov[k]) begin
        chk("sum", k, int'(sum_w[k]), msum[k]);
        chk("err", k, int'(err_w[k]), int'(merr[k]));
      end
      chk("err_cnt", k, int'(cnt_w[k]), mcnt[k]);
    end
  endtask

  initial begin
    int m;
    idle_all();
    mreset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 0, int'(out_valid_w[0]), 0);
    chk("rst_sum", 0, int'(sum_w[0]), 0);
    chk("rst_err_cnt", 0, int'(cnt_w[0]), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 0, int'(in_ready_w[0]), 1);
    @(negedge clk);

    // Approximate mode, window-escaping carry.
    in_valid[0] = 1; mode[0] = 0; a[0] = 16'h7F; b[0] = 16'h01;
    cycle();
    in_valid[0] = 0;
    chk("t1_sum", 0, int'(sum_w[0]), 'h040);
    chk("t1_err", 0, int'(err_w[0]), 1);
    chk("t1_cnt", 0, int'(cnt_w[0]), 1);

    // Exact mode, same operands: one correction bubble.
    in_valid[0] = 1; mode[0] = 1;
    cycle();
    in_valid[0] = 0;
    chk("t2_bubble_ready", 0, int'(in_ready_w[0]), 0);
    chk("t2_bubble_valid", 0, int'(out_valid_w[0]), 0);
    cycle();
    chk("t2_sum", 0, int'(sum_w[0]), 'h080);
    chk("t2_err", 0, int'(err_w[0]), 1);
    chk("t2_cnt", 0, int'(cnt_w[0]), 2);

    // Exact mode with no error: single-cycle latency.
    in_valid[0] = 1; mode[0] = 1; a[0] = 16'hFF; b[0] = 16'hFF;
    cycle();
    in_valid[0] = 0;
    chk("t3_sum", 0, int'(sum_w[0]), 'h1FE);
    chk("t3_err", 0, int'(err_w[0]), 0);
    chk("t3_cnt", 0, int'(cnt_w[0]), 2);

    // Backpressure after the first result of a stream.
    in_valid[0] = 1; mode[0] = 0; a[0] = 16'h0F; b[0] = 16'h01;
    cycle();
    a[0] = 16'h11; b[0] = 16'h22; out_ready[0] = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold_sum", 0, int'(sum_w[0]), 'h010);
      chk("bp_hold_err", 0, int'(err_w[0]), 0);
      chk("bp_hold_ready", 0, int'(in_ready_w[0]), 0);
    end
    out_ready[0] = 1;
    #1;
    chk("bp_release_ready", 0, int'(in_ready_w[0]), 1);
    cycle();
    in_valid[0] = 0;
    chk("bp_next_sum", 0, int'(sum_w[0]), 'h033);
    chk("bp_next_valid", 0, int'(out_valid_w[0]), 1);

    // Counter saturation on the 4-bit counter instance.
    in_valid[1] = 1; mode[1] = 0; a[1] = 16'h7F; b[1] = 16'h01;
    for (int i = 0; i < 20; i++) cycle();
    chk("sat_20", 1, int'(cnt_w[1]), 15);
    cycle();
    chk("sat_hold", 1, int'(cnt_w[1]), 15);
    in_valid[1] = 0;
    cycle();

    // Reset asserted while a correction is in flight.
    in_valid[0] = 1; mode[0] = 1; a[0] = 16'h7F; b[0] = 16'h01;
    cycle();
    in_valid[0] = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 0, int'(out_valid_w[0]), 0);
    chk("mid_rst_sum", 0, int'(sum_w[0]), 0);
    chk("mid_rst_cnt", 0, int'(cnt_w[0]), 0);
    chk("mid_rst_cnt_sat", 1, int'(cnt_w[1]), 0);
    mreset();
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Randomized sweep across all widths and windows.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NCFG; k++) begin
        m = (1 << CW[k]) - 1;
        in_valid[k]  = ($urandom % 4) != 0;
        mode[k]      = 1'($urandom % 2);
        out_ready[k] = ($urandom % 4) != 0;
        a[k] = 16'($urandom & m);
        case ($urandom % 3)
          0:       b[k] = 16'($urandom & m);
          1:       b[k] = 16'((~int'(a[k]) ^ (1 << ($urandom % CW[k]))) & m);
          default: b[k] = 16'((~int'(a[k])) & m);
        endcase
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
